// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory-stage controller (master)
// and the data memory (slave).
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle Y86-64 memory-stage controller: one access per instruction over a req/ack bus.
// Optional MEM_TIMEOUT_EN aborts an access that waits TIMEOUT cycles in REQ with status SADR.
module mem_stage_ctrl #(
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    input  logic              instr_valid,
    input  logic              im_error,
    mem_stage_ctrl_if.master  mem,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] valM,
    output logic [1:0]        status
);
    localparam logic [1:0] SADR = 2'd0;
    localparam logic [1:0] SINS = 2'd1;
    localparam logic [1:0] SHLT = 2'd2;
    localparam logic [1:0] SAOK = 2'd3;
    localparam int         AW   = DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_is_read;
    logic [DATA_W-1:0] r_valM;
    logic [1:0]        r_status;

    logic              w_is_read;
    logic              w_is_write;
    logic              w_is_mem;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [AW-1:0]     w_addr_end;
    logic              w_range_err;
    logic              w_pre_fault;
    logic [1:0]        w_pre_status;
    logic              w_timeout;
    logic              w_in_req;

    // Decode of the instruction presented by execute (only used while IDLE).
    always_comb begin
        w_is_read  = (icode == 4'h5) || (icode == 4'hB) || (icode == 4'h9);
        w_is_write = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
        w_is_mem   = w_is_read || w_is_write;
        w_addr     = ((icode == 4'h9) || (icode == 4'hB)) ? valA : valE;
        w_wdata    = (icode == 4'h8) ? valP : valA;
        // One extra bit so an address near the top of the space cannot wrap into range.
        w_addr_end  = {1'b0, w_addr} + AW'(DATA_W / 8);
        w_range_err = w_is_mem && (w_addr_end > AW'(MEM_BYTES));
        w_pre_fault = im_error || !instr_valid || w_range_err;
        if (im_error || w_range_err) begin
            w_pre_status = SADR;
        end else if (!instr_valid) begin
            w_pre_status = SINS;
        end else if (icode == 4'h0) begin
            w_pre_status = SHLT;
        end else begin
            w_pre_status = SAOK;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_REQ) && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_in_req       = (r_state == S_REQ);
        stall          = (r_state != S_IDLE);
        done           = (r_state == S_RESP);
        mem.mem_req    = w_in_req;
        mem.mem_we     = w_in_req && r_we;
        mem.mem_addr   = w_in_req ? r_addr : '0;
        mem.mem_wdata  = (w_in_req && r_we) ? r_wdata : '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (w_pre_fault || !w_is_mem) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // valM/status only change on the edge entering RESP, so they hold between done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_is_read <= 1'b0;
            r_valM    <= '0;
            r_status  <= SAOK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr    <= w_addr;
                        r_wdata   <= w_wdata;
                        r_we      <= w_is_write;
                        r_is_read <= w_is_read;
                        if (w_pre_fault || !w_is_mem) begin
                            r_status <= w_pre_status;
                            r_valM   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        r_status <= mem.mem_err ? SADR : SAOK;
                        r_valM   <= (r_is_read && !mem.mem_err) ? mem.mem_rdata : '0;
                    end else if (w_timeout) begin
                        r_status <= SADR;
                        r_valM   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valM   = r_valM;
    assign status = r_status;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table plus reset, busy-start and timeout sequences.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        instr_valid, im_error;
    logic        stall, done;
    logic [63:0] valM;
    logic [1:0]  status;

    int n_chk = 0;
    int n_bad = 0;

    mem_stage_ctrl_if #(.DATA_W(64)) bus ();

    mem_stage_ctrl #(
        .DATA_W(64),
        .MEM_BYTES(8192),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .icode(icode),
        .valE(valE),
        .valA(valA),
        .valP(valP),
        .instr_valid(instr_valid),
        .im_error(im_error),
        .mem(bus),
        .stall(stall),
        .done(done),
        .valM(valM),
        .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic        iv;
        logic        ime;
        int          delay;
        logic [63:0] rdata;
        logic        merr;
        int          exp_reqs;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_valM;
        logic [1:0]  exp_status;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          reqs;
        logic        st_ok;
        logic        stable;
        logic        we0;
        logic [63:0] a0;
        logic [63:0] w0;
        we0 = 1'b0;
        a0  = '0;
        w0  = '0;
        @(negedge clk);
        start = 1'b1; icode = v.icode; valE = v.valE; valA = v.valA; valP = v.valP;
        instr_valid = v.iv; im_error = v.ime;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; reqs = 0; st_ok = 1'b1; stable = 1'b1;
        while (!done && cyc < 60) begin
            if (!stall) st_ok = 1'b0;
            if (bus.mem_req) begin
                if (reqs == 0) begin
                    we0 = bus.mem_we; a0 = bus.mem_addr; w0 = bus.mem_wdata;
                end else if (bus.mem_we !== we0 || bus.mem_addr !== a0 || bus.mem_wdata !== w0) begin
                    stable = 1'b0;
                end
                reqs++;
                bus.mem_ack   = (reqs == v.delay + 1);
                bus.mem_rdata = v.rdata;
                bus.mem_err   = v.merr;
            end else begin
                bus.mem_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        chk($sformatf("v%0d done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.exp_lat));
        chk($sformatf("v%0d req_cycles", idx), 64'(reqs), 64'(v.exp_reqs));
        chk($sformatf("v%0d status", idx), 64'(status), 64'(v.exp_status));
        chk($sformatf("v%0d valM", idx), valM, v.exp_valM);
        chk($sformatf("v%0d stall_busy", idx), 64'(st_ok && stall), 64'd1);
        if (v.exp_reqs > 0) begin
            chk($sformatf("v%0d mem_we", idx), 64'(we0), 64'(v.exp_we));
            chk($sformatf("v%0d mem_addr", idx), a0, v.exp_addr);
            chk($sformatf("v%0d req_stable", idx), 64'(stable), 64'd1);
            if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), w0, v.exp_wdata);
        end
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d idle_stall", idx), 64'(stall), 64'd0);
        chk($sformatf("v%0d valM_hold", idx), valM, v.exp_valM);
        chk($sformatf("v%0d status_hold", idx), 64'(status), 64'(v.exp_status));
        $display("vec %0d icode=%0h lat=%0d reqs=%0d status=%0d valM=%0h", idx, v.icode, cyc, reqs, status, valM);
    endtask

    initial begin
        int   cyc;
        int   reqs;
        logic ok;

        //          icode  valE                    valA          valP         iv    ime   d  rdata        merr reqs we    addr          wdata        valM         st  lat
        vecs[0]  = '{4'h4, 64'h100,               64'hDEAD,     64'h5555,    1'b1, 1'b0, 3, 64'h0,       1'b0, 4, 1'b1, 64'h100,     64'hDEAD,    64'h0,       2'd3, 5};
        vecs[1]  = '{4'h5, 64'h18,                64'h0,        64'h0,       1'b1, 1'b0, 0, 64'h1234,    1'b0, 1, 1'b0, 64'h18,      64'h0,       64'h1234,    2'd3, 2};
        vecs[2]  = '{4'hB, 64'h0,                 64'h1FFC,     64'h0,       1'b1, 1'b0, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd0, 1};
        vecs[3]  = '{4'h0, 64'h0,                 64'h0,        64'h0,       1'b1, 1'b0, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd2, 1};
        vecs[4]  = '{4'h0, 64'h0,                 64'h0,        64'h0,       1'b0, 1'b0, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd1, 1};
        vecs[5]  = '{4'h8, 64'h40,                64'h3333,     64'h77,      1'b1, 1'b0, 1, 64'hBAD,     1'b1, 2, 1'b1, 64'h40,      64'h77,      64'h0,       2'd0, 3};
        vecs[6]  = '{4'hB, 64'h8,                 64'h1FF8,     64'h0,       1'b1, 1'b0, 2, 64'hABCD,    1'b0, 3, 1'b0, 64'h1FF8,    64'h0,       64'hABCD,    2'd3, 4};
        vecs[7]  = '{4'hA, 64'h30,                64'h99,       64'h7,       1'b1, 1'b0, 0, 64'h0,       1'b0, 1, 1'b1, 64'h30,      64'h99,      64'h0,       2'd3, 2};
        vecs[8]  = '{4'h1, 64'h0,                 64'h0,        64'h0,       1'b1, 1'b0, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd3, 1};
        vecs[9]  = '{4'h4, 64'h100,               64'h11,       64'h0,       1'b1, 1'b1, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd0, 1};
        vecs[10] = '{4'h4, 64'hFFFFFFFFFFFFFFFC,  64'h11,       64'h0,       1'b1, 1'b0, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd0, 1};
        vecs[11] = '{4'h5, 64'h18,                64'h0,        64'h0,       1'b0, 1'b0, 0, 64'h0,       1'b0, 0, 1'b0, 64'h0,       64'h0,       64'h0,       2'd1, 1};
        vecs[12] = '{4'h5, 64'h20,                64'h0,        64'h0,       1'b1, 1'b0, 0, 64'h77,      1'b1, 1, 1'b0, 64'h20,      64'h0,       64'h0,       2'd0, 2};
        vecs[13] = '{4'h9, 64'h999,               64'h20,       64'h0,       1'b1, 1'b0, 0, 64'h55,      1'b0, 1, 1'b0, 64'h20,      64'h0,       64'h55,      2'd3, 2};

        rst = 1'b1; start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
        instr_valid = 1'b1; im_error = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst mem_addr", bus.mem_addr, 64'd0);
        chk("rst mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst valM", valM, 64'd0);
        chk("rst status", 64'(status), 64'd3);
        $display("reset: req=%0d stall=%0d done=%0d status=%0d", bus.mem_req, stall, done, status);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Reset pulsed while waiting in REQ; a late ack afterwards must be ignored.
        @(negedge clk);
        start = 1'b1; icode = 4'h5; valE = 64'h18; instr_valid = 1'b1; im_error = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid in_req", 64'(bus.mem_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid mem_req", 64'(bus.mem_req), 64'd0);
        chk("rstmid stall", 64'(stall), 64'd0);
        chk("rstmid status", 64'(status), 64'd3);
        chk("rstmid valM", valM, 64'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'hFEED;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_ack done", 64'(done), 64'd0);
        chk("late_ack stall", 64'(stall), 64'd0);
        chk("late_ack valM", valM, 64'd0);
        $display("reset-in-REQ: req=%0d stall=%0d status=%0d", bus.mem_req, stall, status);

        // A start pulse while busy must not disturb the access in flight.
        @(negedge clk);
        start = 1'b1; icode = 4'h4; valE = 64'h100; valA = 64'hDEAD;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; reqs = 0; ok = 1'b1;
        while (!done && cyc < 60) begin
            if (cyc == 2) begin
                start = 1'b1; icode = 4'h5; valE = 64'h200;
            end else begin
                start = 1'b0;
            end
            if (bus.mem_req) begin
                if (bus.mem_addr !== 64'h100 || bus.mem_we !== 1'b1) ok = 1'b0;
                reqs++;
                bus.mem_ack = (reqs == 4);
            end else begin
                bus.mem_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; bus.mem_ack = 1'b0;
        chk("busy latency", 64'(cyc), 64'd5);
        chk("busy addr_kept", 64'(ok), 64'd1);
        chk("busy status", 64'(status), 64'd3);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || bus.mem_req || stall) ok = 1'b0;
        end
        chk("busy start_ignored", 64'(ok), 64'd1);
        $display("busy-start: lat=%0d reqs=%0d status=%0d", cyc, reqs, status);

        // No ack at all: with the timeout the access aborts, otherwise it keeps waiting.
        @(negedge clk);
        start = 1'b1; icode = 4'h4; valE = 64'h100; valA = 64'h1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; reqs = 0;
`ifdef MEM_TIMEOUT_EN
        while (!done && cyc < 60) begin
            if (bus.mem_req) reqs++;
            @(negedge clk);
            cyc++;
        end
        chk("timeout req_cycles", 64'(reqs), 64'd4);
        chk("timeout latency", 64'(cyc), 64'd5);
        chk("timeout status", 64'(status), 64'd0);
        chk("timeout valM", valM, 64'd0);
`else
        ok = 1'b1;
        repeat (12) begin
            if (!bus.mem_req || done) ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("wait no_timeout", 64'(ok), 64'd1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("wait done", 64'(done), 64'd1);
        chk("wait status", 64'(status), 64'd3);
`endif
        $display("no-ack: cycles=%0d done=%0d status=%0d", cyc, done, status);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
